fwd_hazard_ctrl: RTL
====================

# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It drives the 2-bit `sel` of the two EX-stage three-input 32-bit operand muxes (operand A and operand B). It detects load-use hazards and stalls IF/ID, and inserts bubbles into ID/EX on stall or branch flush. It keeps a private shadow of the destination-register info for the EX, MEM and WB stages, so all operand-select decisions are made at decode and registered into EX.

## Interface
Parameters:
- `REG_AW`, default 5: register-index width.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_AW  source register indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction actually reads rs1 / rs2.
- `id_rd`  in  REG_AW  destination index of the ID instruction.
- `id_reg_write`  in  1  ID instruction writes `id_rd`.
- `id_mem_read`  in  1  ID instruction is a load.
- `ex_flush`  in  1  branch/jump taken, resolved in EX this cycle.
- `forward_a`, `forward_b`  out  2  registered operand-mux selects for the instruction currently in EX.
- `stall`  out  1  combinational: hold PC and IF/ID this cycle.
- `idex_bubble`  out  1  combinational: ID/EX loads a NOP this cycle.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- Operand-mux encoding (mux sel[0] picks in2, sel[1] picks in3, in3 dominant):
  - `2'b00` selects in1, the register-file value.
  - `2'b01` selects in2, the WB result.
  - `2'b10` selects in3, the EX/MEM ALU result.
  - `2'b11` is never driven.
- Shadow stages EX, MEM and WB each hold {valid, rd, reg_write, mem_read}.
  - Each cycle: WB←MEM, MEM←EX.
  - EX←ID fields gated by `id_valid & ~idex_bubble`. On a bubble, EX.valid=0.
- A shadow entry is a "producer" when valid & reg_write & rd≠0. Register x0 is never forwarded or stalled on.
- Select computation for operand A, evaluated on the ID instruction (operand B is identical with rs2 / `id_use_rs2`):
  - If `id_use_rs1` and the EX shadow is a producer with rd==rs1, next `forward_a` = 10. That producer will be in MEM when ID reaches EX.
  - Else if the MEM shadow is a producer with rd==rs1, next = 01. It will be in WB.
  - Else next = 00. Register-file write-before-read covers the current WB stage and is the register file's responsibility.
  - EX-shadow match has priority over MEM-shadow match (youngest producer wins).
- Load-use hazard: `stall` = id_valid & EX.valid & EX.mem_read & EX.rd≠0 & ((id_use_rs1 & EX.rd==id_rs1) | (id_use_rs2 & EX.rd==id_rs2)) & ~ex_flush.
- `idex_bubble` = stall | ex_flush.
- On a bubble, the registered `forward_a`/`forward_b` load 00.
- During a stall the ID inputs are unchanged the next cycle. The load has moved to MEM, so the re-evaluated decision yields 01. Every load-use therefore costs exactly one stall cycle.
- `ex_flush` has priority over `stall`:
  - ID is squashed and the EX shadow becomes invalid.
  - `stall` is forced to 0 so fetch redirects.
  - The flushing instruction itself still advances to MEM normally.
- `stall_cnt` increments on every cycle with `stall`=1 and saturates at all-ones (no wrap).

## Timing
- Reset (synchronous): all shadow valids=0, `forward_a`=`forward_b`=00, `stall_cnt`=0. `stall` and `idex_bubble` read 0 from the first post-reset cycle onward.
- `reset` asserted mid-stall or mid-flush takes precedence over everything: state clears at that edge.
- Select latency is 1 cycle. Decision made while the instruction is in ID; value present on `forward_*` for the entire cycle it is in EX.
- `stall`/`idex_bubble` are 0-latency combinational from ID inputs and shadow state. No path from `forward_*` back to them.
- Back-to-back stalls are impossible for a single load. Each stall cycle requires a fresh EX-stage load.

## Test plan
- **EX→EX forwarding:** `add x5` in ID, then `sub` reading rs1=x5 → during sub's EX cycle `forward_a`=10, `forward_b`=00, `stall`=0.
- **MEM→EX forwarding with priority:** producers to x7 two instrs back and one instr back, consumer reads rs2=x7 → `forward_b`=10 (younger wins). With only the older producer → 01.
- **Load-use:** `lw x3` in EX while the ID instr uses rs1=x3 → `stall`=1 and `idex_bubble`=1 for exactly 1 cycle; consumer's EX cycle has `forward_a`=01; `stall_cnt` goes 0→1.
- **x0 and unused sources:** producer writes x0, consumer reads x0 → selects 00, no stall. `lw x4` followed by an instr with `id_use_rs2`=0 and rs2=x4 → no stall.
- **Flush vs stall:** load-use condition and `ex_flush`=1 in the same cycle → `stall`=0, `idex_bubble`=1, next EX selects 00, and no later instruction forwards from the squashed entry.
- **Reset and saturation:** preload `stall_cnt` to all-ones by repeated load-use → it stays all-ones. Assert `reset` mid-stall → next cycle all outputs 0 and shadows invalid (a dependent instr gets 00).

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Operand-mux selects are decided at decode against a private EX/MEM destination shadow and registered into EX.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_WB    = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    // The WB stage needs no shadow: register-file write-before-read covers it.
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;

    logic              ex_prod;
    logic              mem_prod;
    logic              load_use;
    logic [1:0]        fa_next;
    logic [1:0]        fb_next;

    // Youngest producer wins; x0 never matches because producers exclude rd==0.
    function automatic logic [1:0] pick_sel(
        input logic              use_src,
        input logic [REG_AW-1:0] rs,
        input logic              ex_p,
        input logic [REG_AW-1:0] ex_d,
        input logic              mem_p,
        input logic [REG_AW-1:0] mem_d
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (use_src && ex_p && (ex_d == rs)) begin
            sel = SEL_EXMEM;
        end else if (use_src && mem_p && (mem_d == rs)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        ex_prod     = ex_valid & ex_reg_write & (ex_rd != '0);
        mem_prod    = mem_valid & mem_reg_write & (mem_rd != '0);
        load_use    = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
        stall       = load_use & ~ex_flush;
        idex_bubble = stall | ex_flush;
        fa_next     = SEL_RF;
        fb_next     = SEL_RF;
        if (id_valid && !idex_bubble) begin
            fa_next = pick_sel(id_use_rs1, id_rs1, ex_prod, ex_rd, mem_prod, mem_rd);
            fb_next = pick_sel(id_use_rs2, id_rs2, ex_prod, ex_rd, mem_prod, mem_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            forward_a     <= SEL_RF;
            forward_b     <= SEL_RF;
            stall_cnt     <= '0;
        end else begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            ex_valid      <= id_valid & ~idex_bubble;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            forward_a     <= fa_next;
            forward_b     <= fb_next;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
endmodule
